// File: rtl/scfifo_arb_pkg.sv
// Shared types and the cyclic priority pick used by the scfifo write arbiter.
// The pick works on a fixed 16-wide vector, and callers zero-extend narrower request sets.
package scfifo_arb_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        ARB,
        LOCK
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_REQ-1:0]   onehot;
    } rr_pick_t;

    // First set bit of valid at or after ptr, searching cyclically over num_req entries.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          num_req
    );
        rr_pick_t    res;
        int unsigned pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= num_req) begin
                pos = pos - num_req;
            end
            if ((k < num_req) && !res.found && valid[pos[MAX_IDX_W-1:0]]) begin
                res.found                        = 1'b1;
                res.idx                          = pos[MAX_IDX_W-1:0];
                res.onehot[pos[MAX_IDX_W-1:0]]   = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NUM_REQ requests with a registered rotating pointer.
// The pointer moves to one past the winner on every accepted grant.
module rr_arbiter
    import scfifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 sclr,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 en,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [REQ_IDX_W-1:0] gnt_idx,
    output logic                 gnt_valid
);

    logic [REQ_IDX_W-1:0] r_ptr;
    logic [REQ_IDX_W-1:0] w_ptr_nxt;
    rr_pick_t             w_pick;
    logic                 w_unused_pick;

    always_comb begin
        w_pick = rr_pick(MAX_REQ'(req), MAX_IDX_W'(r_ptr), NUM_REQ);
    end

    assign w_unused_pick = ^w_pick;
    assign gnt_valid     = w_pick.found & en;
    assign gnt           = en ? w_pick.onehot[NUM_REQ-1:0] : '0;
    assign gnt_idx       = w_pick.idx[REQ_IDX_W-1:0];

    // Explicit wrap keeps non-power-of-two counts from ever reaching NUM_REQ.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (sclr) begin
            w_ptr_nxt = '0;
        end else if (gnt_valid) begin
            if (gnt_idx == REQ_IDX_W'(NUM_REQ - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = gnt_idx + REQ_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/scfifo_wr_arbiter.sv
// Round-robin write arbiter that feeds one scfifo from NUM_REQ valid/ready producers.
// Define SCFIFO_WR_ARB_PKT_LOCK_EN to hold the grant on one requester until req_last.
module scfifo_wr_arbiter
    import scfifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned LOG_DEPTH  = 8,
    parameter int unsigned FIFO_WORDS = 2**LOG_DEPTH - 3,
    parameter int unsigned REQ_IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     sclr,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [LOG_DEPTH-1:0]     fifo_usedw,
    output logic                     fifo_wrreq,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [REQ_IDX_W-1:0]     grant_idx,
    output logic                     stall
);

    logic                 r_wrreq;
    logic [WIDTH-1:0]     r_data;
    logic [REQ_IDX_W-1:0] r_grant_idx;
    logic                 r_stall;

    logic                 w_wrreq_nxt;
    logic [WIDTH-1:0]     w_data_nxt;
    logic [REQ_IDX_W-1:0] w_grant_idx_nxt;
    logic                 w_stall_nxt;

    logic [LOG_DEPTH:0]   w_fill;
    logic                 w_space_ok;
    logic                 w_en;
    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [REQ_IDX_W-1:0] w_gnt_idx;
    logic                 w_gnt_valid;
    logic [WIDTH-1:0]     w_gnt_data;

    // The in-flight registered write counts as occupied; FIFO reads are ignored.
    assign w_fill     = {1'b0, fifo_usedw} + {{LOG_DEPTH{1'b0}}, r_wrreq};
    assign w_space_ok = w_fill < (LOG_DEPTH + 1)'(FIFO_WORDS);
    assign w_en       = w_space_ok & ~sclr & aclr_n;

`ifdef SCFIFO_WR_ARB_PKT_LOCK_EN
    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [REQ_IDX_W-1:0] r_lock_idx;
    logic [REQ_IDX_W-1:0] w_lock_idx_nxt;

    // While locked only the packet owner competes, so the pick ignores the pointer.
    always_comb begin
        w_req = req_valid;
        if (r_state == LOCK) begin
            w_req = req_valid & (NUM_REQ'(1) << r_lock_idx);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        if (sclr) begin
            w_state_nxt = ARB;
        end else if (w_gnt_valid) begin
            if (req_last[w_gnt_idx]) begin
                w_state_nxt = ARB;
            end else begin
                w_state_nxt    = LOCK;
                w_lock_idx_nxt = w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state    <= ARB;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end
`else
    logic w_unused_last;

    assign w_req         = req_valid;
    assign w_unused_last = ^req_last;
`endif

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_rr_arbiter (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .req       (w_req),
        .en        (w_en),
        .gnt       (w_gnt),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    assign req_ready  = w_gnt;
    assign w_gnt_data = req_data[w_gnt_idx*WIDTH +: WIDTH];

    always_comb begin
        w_wrreq_nxt     = 1'b0;
        w_data_nxt      = r_data;
        w_grant_idx_nxt = r_grant_idx;
        w_stall_nxt     = (|req_valid) & ~w_space_ok & ~sclr;
        if (sclr) begin
            w_data_nxt      = '0;
            w_grant_idx_nxt = '0;
        end else if (w_gnt_valid) begin
            w_wrreq_nxt     = 1'b1;
            w_data_nxt      = w_gnt_data;
            w_grant_idx_nxt = w_gnt_idx;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wrreq     <= 1'b0;
            r_data      <= '0;
            r_grant_idx <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_wrreq     <= w_wrreq_nxt;
            r_data      <= w_data_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    assign fifo_wrreq = r_wrreq;
    assign fifo_data  = r_data;
    assign grant_idx  = r_grant_idx;
    assign stall      = r_stall;

endmodule

// File: tb/tb_scfifo_wr_arbiter.sv
// Self-checking bench for scfifo_wr_arbiter: directed scenarios plus a random run
// against a behavioural round-robin model and a simple FIFO occupancy model.
module tb_scfifo_wr_arbiter;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned WIDTH      = 20;
    localparam int unsigned LOG_DEPTH  = 8;
    localparam int unsigned FIFO_WORDS = 2**LOG_DEPTH - 3;
    localparam int unsigned REQ_IDX_W  = 2;

    logic                     clock = 1'b0;
    logic                     aclr_n;
    logic                     sclr;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic [LOG_DEPTH-1:0]     fifo_usedw;
    logic                     fifo_wrreq;
    logic [WIDTH-1:0]         fifo_data;
    logic [REQ_IDX_W-1:0]     grant_idx;
    logic                     stall;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int               m_ptr;
    int               m_gidx;
    int               m_lock_idx;
    bit               m_wrreq;
    bit               m_stall;
    bit               m_lock;
    logic [WIDTH-1:0] m_data;
    int               occ;

    always #5 clock = ~clock;

    scfifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH      (WIDTH),
        .LOG_DEPTH  (LOG_DEPTH),
        .FIFO_WORDS (FIFO_WORDS),
        .REQ_IDX_W  (REQ_IDX_W)
    ) dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .sclr       (sclr),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_usedw (fifo_usedw),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .grant_idx  (grant_idx),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ptr      = 0;
        m_gidx     = 0;
        m_lock_idx = 0;
        m_wrreq    = 1'b0;
        m_stall    = 1'b0;
        m_lock     = 1'b0;
        m_data     = '0;
    endtask

    function automatic bit model_space();
        return (int'(fifo_usedw) + int'(m_wrreq)) < int'(FIFO_WORDS);
    endfunction

    // Index that should be readied this cycle, or -1.
    function automatic int model_pick();
        if (!aclr_n || sclr || !model_space()) return -1;
        if (m_lock) return req_valid[m_lock_idx] ? m_lock_idx : -1;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (req_valid[(m_ptr + k) % int'(NUM_REQ)]) return (m_ptr + k) % int'(NUM_REQ);
        end
        return -1;
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
    endtask

    task automatic sample();
        int                 g;
        logic [NUM_REQ-1:0] er;
        @(negedge clock);
        g  = model_pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("fifo_wrreq", 64'(fifo_wrreq), 64'(m_wrreq));
        chk("fifo_data", 64'(fifo_data), 64'(m_data));
        chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
        chk("stall", 64'(stall), 64'(m_stall));
    endtask

    task automatic advance();
        int g;
        g = model_pick();
        if (sclr) begin
            model_clear();
        end else begin
            m_stall = (req_valid != '0) && !model_space();
            if (g >= 0) begin
                m_ptr   = (g + 1) % int'(NUM_REQ);
                m_gidx  = g;
                m_data  = req_data[g*WIDTH +: WIDTH];
                m_wrreq = 1'b1;
`ifdef SCFIFO_WR_ARB_PKT_LOCK_EN
                m_lock     = !req_last[g];
                m_lock_idx = g;
`endif
            end else begin
                m_wrreq = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit rd;
        aclr_n     = 1'b0;
        sclr       = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        fifo_usedw = '0;
        model_clear();
        #1;
        chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);
        chk("rst_data", 64'(fifo_data), 64'd0);
        chk("rst_gidx", 64'(grant_idx), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clock);
        #1;
        aclr_n = 1'b1;

        // Idle
        for (int i = 0; i < 2; i++) begin
            sample();
            advance();
        end

        // Fairness: all valid, empty FIFO
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            randomize_data();
            sample();
            chk("fair_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) chk("fair_wrreq", 64'(fifo_wrreq), 64'd1);
            advance();
        end

        // Asynchronous reset mid-stream
        aclr_n = 1'b0;
        #1;
        chk("arst_wrreq", 64'(fifo_wrreq), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        chk("arst_data", 64'(fifo_data), 64'd0);
        model_clear();
        @(posedge clock);
        #1;
        aclr_n    = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("idle_wrreq", 64'(fifo_wrreq), 64'd0);
            advance();
        end

        // Full boundary
        fifo_usedw = LOG_DEPTH'(FIFO_WORDS - 1);
        req_valid  = 4'b0001;
        randomize_data();
        sample();
        chk("full_grant0", 64'(req_ready), 64'd1);
        advance();
        sample();
        chk("full_block", 64'(req_ready), 64'd0);
        advance();
        sample();
        chk("full_stall", 64'(stall), 64'd1);
        advance();
        fifo_usedw = LOG_DEPTH'(FIFO_WORDS - 2);
        sample();
        chk("full_minus2", 64'(req_ready), 64'd1);
        advance();
        fifo_usedw = '0;

        // Sparse: move pointer to 3, then only 2 and 3 valid
        req_valid = 4'b0100;
        sample();
        advance();
        req_valid = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            sample();
            chk("sparse_ready", 64'(req_ready), (k % 2 == 0) ? 64'h8 : 64'h4);
            advance();
        end

        // Synchronous clear with pointer at 1
        req_valid = 4'b0001;
        sample();
        advance();
        req_valid = 4'b0010;
        sclr      = 1'b1;
        sample();
        chk("sclr_ready", 64'(req_ready), 64'd0);
        advance();
        sclr      = 1'b0;
        req_valid = 4'b0011;
        sample();
        chk("sclr_ptr0", 64'(req_ready), 64'd1);
        chk("sclr_wrreq", 64'(fifo_wrreq), 64'd0);
        advance();

`ifdef SCFIFO_WR_ARB_PKT_LOCK_EN
        // Packet lock on requester 1, with a space stall mid-packet
        req_valid = 4'b0111;
        req_last  = 4'b0000;
        randomize_data();
        sample();
        chk("lock_beat1", 64'(req_ready), 64'h2);
        advance();
        fifo_usedw = LOG_DEPTH'(FIFO_WORDS);
        sample();
        chk("lock_stall", 64'(req_ready), 64'd0);
        advance();
        fifo_usedw = '0;
        randomize_data();
        sample();
        chk("lock_beat2", 64'(req_ready), 64'h2);
        advance();
        req_last = 4'b0010;
        sample();
        chk("lock_beat3", 64'(req_ready), 64'h2);
        advance();
        req_last = 4'b0000;
        sample();
        chk("lock_after", 64'(req_ready), 64'h4);
        advance();
        req_last = 4'b1111;
        sample();
        advance();
`endif

        // Random traffic against a FIFO that drains slower than it fills
        occ = 200;
        for (int c = 0; c < 600; c++) begin
            req_valid  = NUM_REQ'($urandom);
            req_last   = NUM_REQ'($urandom);
            sclr       = ($urandom_range(0, 49) == 0);
            randomize_data();
            fifo_usedw = LOG_DEPTH'(occ);
            sample();
            chk("no_write_when_full", 64'(fifo_wrreq && (occ >= int'(FIFO_WORDS))), 64'd0);
            rd  = (occ > 0) && ($urandom_range(0, 99) < 45);
            occ = occ + int'(fifo_wrreq) - int'(rd);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scfifo_wr_arbiter.md
Name: scfifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets NUM_REQ independent producers share one scfifo_s_normal_m20k_r instance.
- Each producer has a valid/ready handshake. The arbiter grants at most one beat per cycle and drives a registered wrreq/data pair into the FIFO.
- Overflow is prevented by gating grants against FIFO occupancy (usedw) plus the in-flight registered write. It does not rely on the FIFO's lagging full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 20, data width; must match the FIFO WIDTH.
- LOG_DEPTH, 8, FIFO address width; sets the usedw width.
- FIFO_WORDS, 2**LOG_DEPTH-3, usable FIFO capacity; must equal the FIFO NUM_WORDS.
- REQ_IDX_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clock  in  1  rising-edge clock.
- aclr_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear of arbiter state (active high).
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NUM_REQ  end-of-packet marker; used only with the optional feature.
- req_ready  out  NUM_REQ  one-hot or zero; a beat transfers when valid & ready.
- fifo_usedw  in  LOG_DEPTH  FIFO usedw output.
- fifo_wrreq  out  1  registered write strobe to the FIFO.
- fifo_data  out  WIDTH  registered write data to the FIFO.
- grant_idx  out  REQ_IDX_W  index of the last granted requester (registered).
- stall  out  1  high when any valid is pending but no grant is possible due to occupancy.

Behaviour:
- Clock and reset: one clock, named clock. Reset aclr_n is asynchronous and active-low.
- Reset (aclr_n=0) and sclr values:
  - fifo_wrreq=0, fifo_data=0, grant_idx=0, stall=0.
  - RR pointer=0, state=ARB.
  - req_ready is combinational and therefore 0.
  - When sclr and aclr_n are both active, aclr_n dominates. sclr forces req_ready=0 in the same cycle.
- Space check (combinational):
  - space_ok = (fifo_usedw + fifo_wrreq) < FIFO_WORDS.
  - The sum is computed at LOG_DEPTH+1 bits, with no wrap.
  - Reads are ignored, which is conservative.
- Arbitration:
  - Among req_valid, pick the first set bit at or after ptr, searching cyclically.
  - req_ready[g]=1 only if space_ok and not sclr.
  - On a transfer:
    - ptr <= (g+1) mod NUM_REQ;
    - grant_idx <= g;
    - fifo_data <= req_data[g];
    - fifo_wrreq <= 1.
  - With no transfer: fifo_wrreq <= 0, fifo_data holds, ptr holds.
- Latency: a handshake in cycle t gives fifo_wrreq=1 in cycle t+1.
- Throughput: one beat per cycle while space_ok.
- Fairness: every continuously-valid requester is granted within NUM_REQ transfers.
- stall = |req_valid & ~space_ok & ~sclr, registered. It reflects the previous cycle.
- Near full: at usedw=FIFO_WORDS-1 with fifo_wrreq=1, space_ok=0 and no grant is issued. The FIFO never sees wrreq while full.
- NUM_REQ not a power of two: ptr wraps from NUM_REQ-1 to 0. Indices at or above NUM_REQ never appear.

Optional Feature:
- Macro: SCFIFO_WR_ARB_PKT_LOCK_EN.
- Defined — packet lock:
  - FSM states ARB and LOCK.
  - A granted beat with req_last[g]=0 moves the FSM to LOCK and holds lock_idx=g.
  - In LOCK, only lock_idx may be granted, regardless of ptr; other requesters see ready=0.
  - A granted beat with req_last=1 returns the FSM to ARB, with ptr=lock_idx+1.
  - space_ok still gates grants in LOCK.
  - sclr or aclr_n returns the FSM to ARB.
- Undefined: req_last is ignored, every beat is arbitrated independently, and no LOCK state exists.

Decomposition:
- Package scfifo_arb_pkg holds:
  - typedef arb_state_t {ARB, LOCK};
  - function rr_pick(valid, ptr) returning a one-hot vector and an index.
- Sub-module rr_arbiter (combinational cyclic priority pick plus registered pointer) is natural and reusable. The top module adds space gating, the data mux/register, and the lock FSM.

Test Plan:
- Reset and idle: aclr_n low mid-stream with fifo_wrreq=1 → fifo_wrreq=0, req_ready=0 immediately. After release with all valid=0 → fifo_wrreq stays 0.
- Fairness, NUM_REQ=4, all valid continuously, usedw=0 held → grants 0,1,2,3,0,…; fifo_wrreq=1 every cycle from t+1; fifo_data follows requester order.
- Full boundary, FIFO_WORDS=253:
  - usedw=252 with fifo_wrreq=0, req0 valid → one grant.
  - Next cycle (usedw=252, wrreq=1) → req_ready=0 and stall=1 the following cycle.
  - usedw=251 with wrreq=1 → grant allowed.
- Sparse requests: only req2 and req3 valid, ptr=3 → grant 3, then 2, then 3. Requesters 0 and 1 are never readied.
- sclr asserted while req1 valid and ptr=1 → no grant that cycle. Next cycle ptr=0, so with req0 and req1 valid, req0 is granted first.
- With SCFIFO_WR_ARB_PKT_LOCK_EN defined: req1 sends a 3-beat packet (last on beat 3) while req0 and req2 are valid → beats 1-3 come only from req1, then req2 is granted. Inserting a space stall mid-packet pauses the packet and does not break the lock.
